// File: rtl/ptp_tsu_if.sv
// Signal bundle for the PTP timestamp unit: GMII snoop input, RTC time, event queue read port.
interface ptp_tsu_if;
    logic        gmii_ctrl;
    logic [7:0]  gmii_data;
    logic [79:0] rtc_timer_in;
    logic        q_rd_en;
    logic [7:0]  q_rd_stat;
    logic [63:0] q_rd_data;
    logic        q_wr_en;
    logic [1:0]  fsm_state;

    // Read handshake: the head entry is valid whenever q_rd_stat != 0 and q_rd_en is the ready;
    // an entry is consumed only on a rising edge where both are true. q_wr_en is a push strobe
    // with no back-pressure: a push into a full queue is dropped.
    modport slave (
        input  gmii_ctrl, gmii_data, rtc_timer_in, q_rd_en,
        output q_rd_stat, q_rd_data, q_wr_en, fsm_state
    );
    modport master (
        output gmii_ctrl, gmii_data, rtc_timer_in, q_rd_en,
        input  q_rd_stat, q_rd_data, q_wr_en, fsm_state
    );
endinterface

// File: rtl/ptp_tsu.sv
// PTP timestamp unit: detects L2 / IPv4-UDP:319 PTP event frames on a GMII byte stream and
// queues {msgType, sequenceId, SFD time} entries in a first-word-fall-through circular buffer.
module ptp_tsu #(
    parameter int QADDR_W = 4
) (
    input logic      gmii_clk,
    input logic      rst_n,
    ptp_tsu_if.slave bus
);
    localparam int DEPTH = 1 << QADDR_W;
    localparam logic [QADDR_W:0] FULL = (QADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PRE, DATA, WAIT} state_t;

    state_t             state_q, state_d;
    logic [6:0]         idx_q, idx_d;
    logic               udp_q, udp_d;
    logic [3:0]         msg_type_q, msg_type_d;
    logic [7:0]         seq_hi_q, seq_hi_d;
    logic [43:0]        ts_q, ts_d;
    logic               wr_en_q, wr_en_d;
    logic [63:0]        entry_q, entry_d;
    logic [QADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [QADDR_W:0]   count_q, count_d;
    logic [63:0]        mem_q [DEPTH];
    logic               do_push, do_pop, push_frame;
    logic [7:0]         din;
    logic               unused_rtc;

    assign din        = bus.gmii_data;
    assign unused_rtc = ^bus.rtc_timer_in[79:44];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        udp_d      = udp_q;
        msg_type_d = msg_type_q;
        seq_hi_d   = seq_hi_q;
        ts_d       = ts_q;
        entry_d    = entry_q;
        wr_en_d    = 1'b0;
        push_frame = 1'b0;
        if (!bus.gmii_ctrl) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (din == 8'h55) state_d = PRE;
                PRE: begin
                    if (din == 8'hD5) begin
                        state_d = DATA;
                        idx_d   = 7'd0;
                        ts_d    = bus.rtc_timer_in[43:0];
                    end else if (din != 8'h55) begin
                        state_d = WAIT;
                    end
                end
                DATA: begin
                    idx_d = (idx_q == 7'd127) ? idx_q : idx_q + 7'd1;
                    case (idx_q)
                        7'd12: begin
                            if (din == 8'h88)      udp_d = 1'b0;
                            else if (din == 8'h08) udp_d = 1'b1;
                            else                   state_d = WAIT;
                        end
                        7'd13: if (din != (udp_q ? 8'h00 : 8'hF7)) state_d = WAIT;
                        7'd14: begin
                            if (udp_q) begin
                                if (din != 8'h45) state_d = WAIT;
                            end else begin
                                msg_type_d = din[3:0];
                                if (din[3:2] != 2'b00) state_d = WAIT;
                            end
                        end
                        7'd23: if (udp_q && din != 8'h11) state_d = WAIT;
                        7'd36: if (udp_q && din != 8'h01) state_d = WAIT;
                        7'd37: if (udp_q && din != 8'h3F) state_d = WAIT;
                        7'd42: begin
                            if (udp_q) begin
                                msg_type_d = din[3:0];
                                if (din[3:2] != 2'b00) state_d = WAIT;
                            end
                        end
                        7'd44: if (!udp_q) seq_hi_d = din;
                        7'd45: if (!udp_q) push_frame = 1'b1;
                        7'd72: if (udp_q) seq_hi_d = din;
                        7'd73: if (udp_q) push_frame = 1'b1;
                        default: ;
                    endcase
                    // The seqId low byte is taken straight off the bus; the entry lands one edge later.
                    if (push_frame) begin
                        wr_en_d = 1'b1;
                        entry_d = {msg_type_q, seq_hi_q, din, ts_q};
                        state_d = WAIT;
                    end
                end
                WAIT: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        do_push  = wr_en_q && (count_q != FULL);
        do_pop   = bus.q_rd_en && (count_q != '0);
        wr_ptr_d = wr_ptr_q + QADDR_W'(do_push);
        rd_ptr_d = rd_ptr_q + QADDR_W'(do_pop);
        count_d  = count_q + (QADDR_W + 1)'(do_push) - (QADDR_W + 1)'(do_pop);
    end

    always_ff @(posedge gmii_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            udp_q      <= 1'b0;
            msg_type_q <= '0;
            seq_hi_q   <= '0;
            ts_q       <= '0;
            wr_en_q    <= 1'b0;
            entry_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            udp_q      <= udp_d;
            msg_type_q <= msg_type_d;
            seq_hi_q   <= seq_hi_d;
            ts_q       <= ts_d;
            wr_en_q    <= wr_en_d;
            entry_q    <= entry_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: an empty count masks the read data.
    always_ff @(posedge gmii_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= entry_q;
    end

    assign bus.q_rd_stat = 8'(count_q);
    assign bus.q_rd_data = (count_q == '0) ? 64'd0 : mem_q[rd_ptr_q];
    assign bus.q_wr_en   = wr_en_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_ptp_tsu.sv
// Self-checking bench for ptp_tsu: random PTP/non-PTP frames against a frame-level reference model.
module tb_ptp_tsu;
    localparam int QADDR_W = 4;
    localparam int DEPTH   = 16;

    logic gmii_clk = 1'b0;
    logic rst_n    = 1'b0;

    ptp_tsu_if bus();

    ptp_tsu #(.QADDR_W(QADDR_W)) dut (
        .gmii_clk (gmii_clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 gmii_clk = ~gmii_clk;

    logic [63:0] exp_q[$];
    logic [7:0]  frame_buf [128];
    int          frame_len;
    logic [79:0] sfd_rtc;
    int          checks    = 0;
    int          failures  = 0;
    int          wr_pulses = 0;
    int          exp_pulses = 0;

    always @(negedge gmii_clk) if (bus.q_wr_en === 1'b1) wr_pulses <= wr_pulses + 1;

    function automatic logic [79:0] rand80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // Reference: decide from the whole captured frame whether it is a PTP event frame.
    function automatic bit model_event(output logic [63:0] entry);
        logic [15:0] et;
        et    = {frame_buf[12], frame_buf[13]};
        entry = '0;
        if (frame_len >= 46 && et == 16'h88F7 && frame_buf[14][3:0] < 4) begin
            entry = {frame_buf[14][3:0], frame_buf[44], frame_buf[45], sfd_rtc[43:0]};
            return 1'b1;
        end
        if (frame_len >= 74 && et == 16'h0800 && frame_buf[14] == 8'h45 && frame_buf[23] == 8'h11 &&
            {frame_buf[36], frame_buf[37]} == 16'd319 && frame_buf[42][3:0] < 4) begin
            entry = {frame_buf[42][3:0], frame_buf[72], frame_buf[73], sfd_rtc[43:0]};
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic build_l2(input logic [3:0] mt, input logic [15:0] seq);
        frame_len = 64;
        for (int i = 0; i < 128; i++) frame_buf[i] = 8'($urandom);
        frame_buf[12] = 8'h88;
        frame_buf[13] = 8'hF7;
        frame_buf[14] = {4'($urandom), mt};
        frame_buf[44] = seq[15:8];
        frame_buf[45] = seq[7:0];
    endtask

    task automatic build_udp(input logic [3:0] mt, input logic [15:0] seq, input logic [15:0] port);
        frame_len = 90;
        for (int i = 0; i < 128; i++) frame_buf[i] = 8'($urandom);
        frame_buf[12] = 8'h08;
        frame_buf[13] = 8'h00;
        frame_buf[14] = 8'h45;
        frame_buf[23] = 8'h11;
        frame_buf[36] = port[15:8];
        frame_buf[37] = port[7:0];
        frame_buf[42] = {4'($urandom), mt};
        frame_buf[72] = seq[15:8];
        frame_buf[73] = seq[7:0];
    endtask

    // Drives preamble, SFD (with the given RTC) and the frame; stop_at truncates, rst_at pulses reset,
    // pop_on_push raises q_rd_en for exactly the edge that writes the pushed entry.
    task automatic send_frame(input logic [79:0] rtc, input int stop_at, input int rst_at,
                              input bit pop_on_push);
        int          pre;
        int          n;
        bit          popped;
        bit          reset_hit;
        logic [63:0] ent;
        pre       = $urandom_range(1, 7);
        popped    = 1'b0;
        reset_hit = 1'b0;
        for (int i = 0; i < pre; i++) begin
            @(negedge gmii_clk);
            bus.gmii_ctrl    = 1'b1;
            bus.gmii_data    = 8'h55;
            bus.rtc_timer_in = rand80();
        end
        sfd_rtc = rtc;
        @(negedge gmii_clk);
        bus.gmii_data    = 8'hD5;
        bus.rtc_timer_in = rtc;
        n = (stop_at >= 0) ? stop_at : frame_len;
        for (int i = 0; i < n; i++) begin
            @(negedge gmii_clk);
            if (pop_on_push && !popped && bus.q_wr_en === 1'b1) begin
                bus.q_rd_en = 1'b1;
                popped      = 1'b1;
            end else begin
                bus.q_rd_en = 1'b0;
            end
            if (i == rst_at) begin
                rst_n     = 1'b0;
                reset_hit = 1'b1;
            end
            bus.gmii_data    = frame_buf[i];
            bus.rtc_timer_in = rand80();
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge gmii_clk);
            bus.gmii_ctrl = 1'b0;
            bus.gmii_data = 8'h00;
            bus.q_rd_en   = 1'b0;
            if (i == 1) rst_n = 1'b1;
        end
        frame_len = n;
        if (reset_hit) begin
            exp_q.delete();
        end else if (model_event(ent)) begin
            exp_pulses++;
            if (popped && exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_q.size() < DEPTH) exp_q.push_back(ent);
        end
    endtask

    task automatic pop_one();
        @(negedge gmii_clk);
        bus.q_rd_en = 1'b1;
        @(negedge gmii_clk);
        bus.q_rd_en = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic test_reset();
        repeat (3) @(negedge gmii_clk);
        checks += 3;
        if (bus.q_rd_stat !== 8'd0) begin failures++; $display("FAIL reset_stat got=%0d want=0", bus.q_rd_stat); end
        if (bus.q_rd_data !== 64'd0) begin failures++; $display("FAIL reset_data got=%h want=0", bus.q_rd_data); end
        if (bus.q_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b want=0", bus.q_wr_en); end
        rst_n = 1'b1;
        repeat (2) @(negedge gmii_clk);
        checks++;
        if (bus.q_rd_stat !== 8'd0) begin failures++; $display("FAIL post_reset_stat got=%0d want=0", bus.q_rd_stat); end
    endtask

    task automatic test_l2_sync();
        int p0;
        p0 = wr_pulses;
        build_l2(4'd0, 16'h1234);
        send_frame(80'h0000_0000_0ABC_0000_0064, -1, -1, 1'b0);
        checks += 3;
        if (wr_pulses - p0 != 1) begin failures++; $display("FAIL l2_pulses got=%0d want=1", wr_pulses - p0); end
        if (bus.q_rd_stat !== 8'd1) begin failures++; $display("FAIL l2_stat got=%0d want=1", bus.q_rd_stat); end
        if (bus.q_rd_data !== 64'h0_1234_ABC_00000064) begin
            failures++; $display("FAIL l2_data got=%h want=%h", bus.q_rd_data, 64'h0_1234_ABC_00000064);
        end
        pop_one();
    endtask

    task automatic test_udp();
        int p0;
        p0 = wr_pulses;
        build_udp(4'd1, 16'h0007, 16'd319);
        send_frame(rand80(), -1, -1, 1'b0);
        checks += 3;
        if (bus.q_rd_data[63:60] !== 4'd1 || bus.q_rd_data[59:44] !== 16'h0007) begin
            failures++; $display("FAIL udp_fields got=%h want type=1 seq=0007", bus.q_rd_data);
        end
        if (bus.q_rd_data !== exp_q[0]) begin failures++; $display("FAIL udp_entry got=%h want=%h", bus.q_rd_data, exp_q[0]); end
        if (wr_pulses - p0 != 1) begin failures++; $display("FAIL udp_pulses got=%0d want=1", wr_pulses - p0); end
        pop_one();
        p0 = wr_pulses;
        frame_len = 90;
        frame_buf[37] = 8'h40;
        send_frame(rand80(), -1, -1, 1'b0);
        checks += 2;
        if (wr_pulses != p0) begin failures++; $display("FAIL udp320_pulses got=%0d want=0", wr_pulses - p0); end
        if (bus.q_rd_stat !== 8'd0) begin failures++; $display("FAIL udp320_stat got=%0d want=0", bus.q_rd_stat); end
    endtask

    task automatic test_non_event();
        int p0;
        p0 = wr_pulses;
        build_l2(4'd8, 16'h0101);
        send_frame(rand80(), -1, -1, 1'b0);
        build_l2(4'd0, 16'h0202);
        frame_buf[12] = 8'h08;
        frame_buf[13] = 8'h06;
        send_frame(rand80(), -1, -1, 1'b0);
        build_l2(4'd2, 16'h0303);
        send_frame(rand80(), 30, -1, 1'b0);
        build_l2(4'd0, 16'h0404);
        frame_buf[12] = 8'h81;
        frame_buf[13] = 8'h00;
        send_frame(rand80(), -1, -1, 1'b0);
        checks += 2;
        if (wr_pulses != p0) begin failures++; $display("FAIL nonevent_pulses got=%0d want=0", wr_pulses - p0); end
        if (bus.q_rd_stat !== 8'd0) begin failures++; $display("FAIL nonevent_stat got=%0d want=0", bus.q_rd_stat); end
    endtask

    task automatic test_full();
        int p0;
        p0 = wr_pulses;
        for (int i = 0; i < 17; i++) begin
            build_l2(4'($urandom_range(0, 3)), 16'(i));
            send_frame(rand80(), -1, -1, 1'b0);
        end
        checks += 2;
        if (wr_pulses - p0 != 17) begin failures++; $display("FAIL full_pulses got=%0d want=17", wr_pulses - p0); end
        if (bus.q_rd_stat !== 8'd16) begin failures++; $display("FAIL full_stat got=%0d want=16", bus.q_rd_stat); end
        for (int i = 0; i < 16; i++) begin
            checks += 2;
            if (bus.q_rd_data[59:44] !== 16'(i)) begin
                failures++; $display("FAIL full_seq%0d got=%h want=%h", i, bus.q_rd_data[59:44], 16'(i));
            end
            if (bus.q_rd_data !== exp_q[0]) begin
                failures++; $display("FAIL full_entry%0d got=%h want=%h", i, bus.q_rd_data, exp_q[0]);
            end
            pop_one();
        end
        checks += 2;
        if (bus.q_rd_stat !== 8'd0) begin failures++; $display("FAIL drain_stat got=%0d want=0", bus.q_rd_stat); end
        if (bus.q_rd_data !== 64'd0) begin failures++; $display("FAIL drain_data got=%h want=0", bus.q_rd_data); end
        pop_one();
        checks++;
        if (bus.q_rd_stat !== 8'd0) begin failures++; $display("FAIL empty_pop_stat got=%0d want=0", bus.q_rd_stat); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            build_udp(4'($urandom_range(0, 3)), 16'($urandom), 16'd319);
            send_frame(rand80(), -1, -1, 1'b0);
        end
        build_l2(4'($urandom_range(0, 3)), 16'($urandom));
        send_frame(rand80(), -1, -1, 1'b1);
        checks += 2;
        if (bus.q_rd_stat !== 8'd3) begin failures++; $display("FAIL b2b_stat got=%0d want=3", bus.q_rd_stat); end
        if (bus.q_rd_data !== exp_q[0]) begin failures++; $display("FAIL b2b_head got=%h want=%h", bus.q_rd_data, exp_q[0]); end
        while (exp_q.size() > 0) begin
            checks++;
            if (bus.q_rd_data !== exp_q[0]) begin failures++; $display("FAIL b2b_drain got=%h want=%h", bus.q_rd_data, exp_q[0]); end
            pop_one();
        end
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        for (int i = 0; i < 2; i++) begin
            build_l2(4'd1, 16'($urandom));
            send_frame(rand80(), -1, -1, 1'b0);
        end
        p0 = wr_pulses;
        build_l2(4'd0, 16'h5555);
        send_frame(rand80(), -1, 20, 1'b0);
        checks += 3;
        if (wr_pulses != p0) begin failures++; $display("FAIL rst_pulses got=%0d want=0", wr_pulses - p0); end
        if (bus.q_rd_stat !== 8'd0) begin failures++; $display("FAIL rst_stat got=%0d want=0", bus.q_rd_stat); end
        if (bus.q_rd_data !== 64'd0) begin failures++; $display("FAIL rst_data got=%h want=0", bus.q_rd_data); end
        build_l2(4'd3, 16'($urandom));
        send_frame(rand80(), -1, -1, 1'b0);
        checks += 2;
        if (bus.q_rd_stat !== 8'd1) begin failures++; $display("FAIL rst_next_stat got=%0d want=1", bus.q_rd_stat); end
        if (bus.q_rd_data !== exp_q[0]) begin failures++; $display("FAIL rst_next_data got=%h want=%h", bus.q_rd_data, exp_q[0]); end
        pop_one();
    endtask

    task automatic test_random();
        int p0;
        int e0;
        p0 = wr_pulses;
        e0 = exp_pulses;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 0)
                build_l2(4'($urandom_range(0, 5)), 16'($urandom));
            else
                build_udp(4'($urandom_range(0, 5)), 16'($urandom), ($urandom_range(0, 3) == 0) ? 16'd320 : 16'd319);
            send_frame(rand80(), -1, -1, 1'b0);
            checks += 2;
            if (bus.q_rd_stat !== 8'(exp_q.size())) begin
                failures++; $display("FAIL rnd_stat%0d got=%0d want=%0d", i, bus.q_rd_stat, exp_q.size());
            end
            if (bus.q_rd_data !== ((exp_q.size() > 0) ? exp_q[0] : 64'd0)) begin
                failures++; $display("FAIL rnd_data%0d got=%h", i, bus.q_rd_data);
            end
            if ($urandom_range(0, 2) == 0) pop_one();
        end
        checks++;
        if (wr_pulses - p0 != exp_pulses - e0) begin
            failures++; $display("FAIL rnd_pulses got=%0d want=%0d", wr_pulses - p0, exp_pulses - e0);
        end
    endtask

    initial begin
        bus.gmii_ctrl    = 1'b0;
        bus.gmii_data    = 8'h00;
        bus.rtc_timer_in = '0;
        bus.q_rd_en      = 1'b0;
        test_reset();
        test_l2_sync();
        test_udp();
        test_non_event();
        test_full();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
